// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-FU 2-deep result buffers, round-robin pick, one registered broadcast per cycle.
// Latency: a result reaches the CDB on the edge after the one that buffered it (two edges from offer to broadcast).
// Backpressure: fu_ready[i] drops only while FU i's buffer is full; tag-0 results are accepted and discarded.

module cdb_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [1:0]   cnt,
    output logic [W-1:0] head
);
    logic [W-1:0] mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   cnt_q;

    assign cnt  = cnt_q;
    assign head = mem[rd_ptr];

    // Pointer and occupancy tracking; flush discards everything buffered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt_q  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Entry storage is data only; validity lives in cnt_q, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end
endmodule

module cdb_arbiter #(
    parameter int XLEN   = 32,
    parameter int NUM_FU = 4,
    parameter int TAG_W  = 6
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic [NUM_FU-1:0]              fu_valid,
    output logic [NUM_FU-1:0]              fu_ready,
    input  logic [NUM_FU*TAG_W-1:0]        fu_tag,
    input  logic [NUM_FU*XLEN-1:0]         fu_result,
    output logic                           cdb_valid,
    output logic [TAG_W-1:0]               cdb_tag,
    output logic [XLEN-1:0]                cdb_result,
    output logic [$clog2(2*NUM_FU+1)-1:0]  pending_cnt
);
    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int CNT_W = $clog2(2*NUM_FU+1);
    localparam int ENT_W = TAG_W + XLEN;

    logic [1:0]       cnt [NUM_FU];
    logic [ENT_W-1:0] head [NUM_FU];
    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] pop;
    logic [NUM_FU-1:0] nonempty;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] rr_nxt;
    logic [PTR_W-1:0] grant_idx;
    logic             grant_vld;
    logic [ENT_W-1:0] sel_head;
    logic [CNT_W-1:0] pend_sum;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FU; gi++) begin : g_fu
            // Ready looks only at the registered count, never at this cycle's pop.
            assign fu_ready[gi] = (cnt[gi] != 2'd2);
            assign nonempty[gi] = (cnt[gi] != 2'd0);
            // Tag 0 means "no destination": handshake completes but nothing is stored.
            assign push[gi] = fu_valid[gi] & fu_ready[gi] & ~flush
                            & (fu_tag[gi*TAG_W +: TAG_W] != '0);
            assign pop[gi]  = grant_vld & ~flush & (grant_idx == PTR_W'(gi));

            cdb_fifo2 #(.W(ENT_W)) u_fifo (
                .clk      (clk),
                .rst_n    (rst_n),
                .flush    (flush),
                .push     (push[gi]),
                .push_dat ({fu_tag[gi*TAG_W +: TAG_W], fu_result[gi*XLEN +: XLEN]}),
                .pop      (pop[gi]),
                .cnt      (cnt[gi]),
                .head     (head[gi])
            );
        end
    endgenerate

    // Round-robin search: first non-empty buffer at or above rr_ptr, wrapping.
    always_comb begin : p_grant
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_FU)) sum = sum - (PTR_W+1)'(NUM_FU);
            idx = sum[PTR_W-1:0];
            if (!grant_vld && nonempty[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
        end
    end

    assign sel_head = head[grant_idx];
    assign rr_nxt   = (grant_idx == PTR_W'(NUM_FU-1)) ? '0 : grant_idx + PTR_W'(1);

    // Broadcast register and priority pointer; flush wins over any grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid  <= 1'b0;
            cdb_tag    <= '0;
            cdb_result <= '0;
            rr_ptr     <= '0;
        end else if (flush) begin
            cdb_valid  <= 1'b0;
            rr_ptr     <= '0;
        end else if (grant_vld) begin
            cdb_valid             <= 1'b1;
            {cdb_tag, cdb_result} <= sel_head;
            rr_ptr                <= rr_nxt;
        end else begin
            cdb_valid  <= 1'b0;
        end
    end

    // Total occupancy across every FU buffer.
    always_comb begin
        pend_sum = '0;
        for (int k = 0; k < NUM_FU; k++) pend_sum = pend_sum + CNT_W'(cnt[k]);
    end

    assign pending_cnt = pend_sum;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios then random traffic against a queue-level model.
// Outputs are sampled on the falling edge; inputs change right after it.
// Model tracks per-FU buffer contents, round-robin pointer and the expected broadcast.

module tb_cdb_arbiter;
    localparam int XLEN   = 32;
    localparam int NUM_FU = 4;
    localparam int TAG_W  = 6;
    localparam int CNT_W  = $clog2(2*NUM_FU+1);

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    flush = 1'b0;
    logic [NUM_FU-1:0]       fu_valid = '0;
    logic [NUM_FU-1:0]       fu_ready;
    logic [NUM_FU*TAG_W-1:0] fu_tag = '0;
    logic [NUM_FU*XLEN-1:0]  fu_result = '0;
    logic                    cdb_valid;
    logic [TAG_W-1:0]        cdb_tag;
    logic [XLEN-1:0]         cdb_result;
    logic [CNT_W-1:0]        pending_cnt;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    int               mn [NUM_FU];
    logic [TAG_W-1:0] mtag [NUM_FU][2];
    logic [XLEN-1:0]  mres [NUM_FU][2];
    int               rr;
    bit               ev;
    logic [TAG_W-1:0] et;
    logic [XLEN-1:0]  er;

    cdb_arbiter #(.XLEN(XLEN), .NUM_FU(NUM_FU), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .fu_valid    (fu_valid),
        .fu_ready    (fu_ready),
        .fu_tag      (fu_tag),
        .fu_result   (fu_result),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_result  (cdb_result),
        .pending_cnt (pending_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_FU; i++) mn[i] = 0;
        rr = 0;
        ev = 1'b0;
        et = '0;
        er = '0;
    endtask

    function automatic int model_total();
        int s = 0;
        for (int i = 0; i < NUM_FU; i++) s += mn[i];
        return s;
    endfunction

    // Advance the model by one rising edge using the currently driven inputs.
    task automatic model_step();
        bit rdy [NUM_FU];
        bit found;
        int g;
        int idx;
        for (int i = 0; i < NUM_FU; i++) rdy[i] = (mn[i] < 2);
        if (flush) begin
            for (int i = 0; i < NUM_FU; i++) mn[i] = 0;
            rr = 0;
            ev = 1'b0;
        end else begin
            found = 1'b0;
            g = 0;
            for (int k = 0; k < NUM_FU; k++) begin
                idx = (rr + k) % NUM_FU;
                if (!found && mn[idx] > 0) begin
                    found = 1'b1;
                    g = idx;
                end
            end
            ev = found;
            if (found) begin
                et = mtag[g][0];
                er = mres[g][0];
                mtag[g][0] = mtag[g][1];
                mres[g][0] = mres[g][1];
                mn[g]--;
                rr = (g + 1) % NUM_FU;
            end
            for (int i = 0; i < NUM_FU; i++) begin
                if (fu_valid[i] && rdy[i] && fu_tag[i*TAG_W +: TAG_W] != '0) begin
                    mtag[i][mn[i]] = fu_tag[i*TAG_W +: TAG_W];
                    mres[i][mn[i]] = fu_result[i*XLEN +: XLEN];
                    mn[i]++;
                end
            end
        end
    endtask

    task automatic set_fu(input int i, input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] res);
        fu_valid[i] = 1'b1;
        fu_tag[i*TAG_W +: TAG_W] = tag;
        fu_result[i*XLEN +: XLEN] = res;
    endtask

    task automatic idle();
        fu_valid = '0;
        flush = 1'b0;
    endtask

    // One clock: check ready, update model, cross the edge, check outputs.
    task automatic cycle();
        logic [NUM_FU-1:0] exp_rdy;
        for (int i = 0; i < NUM_FU; i++) exp_rdy[i] = (mn[i] < 2);
        chk("fu_ready", fu_ready, exp_rdy);
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("cdb_valid", cdb_valid, ev);
        chk("cdb_tag", cdb_tag, et);
        chk("cdb_result", cdb_result, er);
        chk("pending_cnt", pending_cnt, model_total());
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_cdb_valid", cdb_valid, 0);
        chk("rst_cdb_tag", cdb_tag, 0);
        chk("rst_cdb_result", cdb_result, 0);
        chk("rst_pending", pending_cnt, 0);
        chk("rst_ready", fu_ready, {NUM_FU{1'b1}});
        model_reset();
        idle();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        #3;
        chk("init_cdb_valid", cdb_valid, 0);
        chk("init_cdb_tag", cdb_tag, 0);
        chk("init_cdb_result", cdb_result, 0);
        chk("init_pending", pending_cnt, 0);
        chk("init_ready", fu_ready, {NUM_FU{1'b1}});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single result from FU1
        set_fu(1, 6'd5, 32'hDEAD_BEEF);
        cycle();
        chk("single_not_bypassed", cdb_valid, 0);
        idle();
        cycle();
        chk("single_vld", cdb_valid, 1);
        chk("single_tag", cdb_tag, 5);
        chk("single_res", cdb_result, 32'hDEAD_BEEF);
        cycle();
        chk("single_done", cdb_valid, 0);

        // Contention with rr_ptr forced back to 0
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        for (int i = 0; i < NUM_FU; i++) set_fu(i, TAG_W'(i + 1), $urandom);
        cycle();
        chk("cont_pend_start", pending_cnt, 4);
        idle();
        for (int k = 0; k < NUM_FU; k++) begin
            cycle();
            chk("cont_vld", cdb_valid, 1);
            chk("cont_tag", cdb_tag, k + 1);
            chk("cont_pend", pending_cnt, 3 - k);
        end

        // Tag zero is swallowed
        set_fu(3, 6'd0, 32'h1234);
        cycle();
        chk("tag0_pend", pending_cnt, 0);
        chk("tag0_vld", cdb_valid, 0);
        idle();
        cycle();
        chk("tag0_vld_late", cdb_valid, 0);

        // Backpressure: FU0 streams while FU2 fills up
        for (int c = 0; c < 8; c++) begin
            idle();
            set_fu(0, TAG_W'($urandom_range(1, 63)), $urandom);
            if (c < 3) set_fu(2, TAG_W'(40 + c), $urandom);
            cycle();
        end
        idle();
        repeat (8) cycle();

        // Flush with 5 entries pending and a same-cycle FU0 offer
        for (int i = 0; i < NUM_FU; i++) set_fu(i, TAG_W'(10 + i), $urandom);
        cycle();
        idle();
        set_fu(0, 6'd14, $urandom);
        set_fu(1, 6'd15, $urandom);
        cycle();
        chk("flush_pre_pend", pending_cnt, 5);
        idle();
        flush = 1'b1;
        set_fu(0, 6'd20, 32'hBAD0_0000);
        cycle();
        chk("flush_pend", pending_cnt, 0);
        chk("flush_vld", cdb_valid, 0);
        idle();
        repeat (3) cycle();
        for (int i = 0; i < NUM_FU; i++) set_fu(i, TAG_W'(21 + i), $urandom);
        cycle();
        idle();
        cycle();
        chk("flush_rr_zero", cdb_tag, 21);
        repeat (4) cycle();

        // Async reset with 3 entries pending
        for (int i = 0; i < 3; i++) set_fu(i, TAG_W'(30 + i), $urandom);
        cycle();
        chk("mid_rst_pend", pending_cnt, 3);
        async_reset();
        repeat (4) cycle();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) async_reset();
            flush = ($urandom_range(0, 31) == 0);
            for (int i = 0; i < NUM_FU; i++) begin
                fu_valid[i] = ($urandom_range(0, 2) != 0);
                fu_tag[i*TAG_W +: TAG_W] = ($urandom_range(0, 7) == 0) ? '0 : TAG_W'($urandom_range(1, 63));
                fu_result[i*XLEN +: XLEN] = $urandom;
            end
            cycle();
        end
        idle();
        repeat (10) cycle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter XLEN, default 32, result data width.
REQ-002 Parameter NUM_FU, default 4, number of functional-unit (FU) result ports.
REQ-003 Parameter TAG_W, default 6, physical register tag width.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 flush  input  1  synchronous pipeline flush.
REQ-007 fu_valid  input  NUM_FU  per-FU result offer.
REQ-008 fu_ready  output  NUM_FU  per-FU acceptance; a result transfers when valid and ready are both high on the same edge.
REQ-009 fu_tag  input  NUM_FU*TAG_W  packed destination physical tags; FU i occupies bits [i*TAG_W +: TAG_W].
REQ-010 fu_result  input  NUM_FU*XLEN  packed results; FU i occupies bits [i*XLEN +: XLEN].
REQ-011 cdb_valid  output  1  broadcast valid, registered.
REQ-012 cdb_tag  output  TAG_W  broadcast physical tag, registered.
REQ-013 cdb_result  output  XLEN  broadcast data, registered.
REQ-014 pending_cnt  output  clog2(2*NUM_FU+1)  total entries held across all buffers.

Function
REQ-015 Each FU SHALL own a 2-entry FIFO of {tag, result}.
REQ-016 fu_ready[i] SHALL be high whenever FIFO i holds fewer than 2 entries.
- Purely a function of the registered count.
- Independent of fu_valid and of the same-cycle pop.
REQ-017 An accepted result with tag 0 SHALL be consumed (handshake completes) but SHALL NOT be written to the FIFO or broadcast.
REQ-018 Each cycle, the arbiter SHALL select one non-empty FIFO.
- Round-robin: search starts at priority pointer rr_ptr and proceeds upward, wrapping modulo NUM_FU.
REQ-019 The selected FIFO's head SHALL be popped and registered onto cdb_valid/cdb_tag/cdb_result at the next edge.
REQ-020 After a grant to FU g, rr_ptr SHALL become (g+1) mod NUM_FU; with no grant, rr_ptr is unchanged.
REQ-021 With all FIFOs empty, cdb_valid SHALL be 0 at the next edge; cdb_tag and cdb_result hold their previous values.
REQ-022 Latency: a result accepted at edge k into an empty FIFO that wins arbitration SHALL appear on the CDB after edge k+1; it is never bypassed at edge k.
REQ-023 Push and pop on the same FIFO in the same cycle SHALL leave the count unchanged and preserve FIFO order.
REQ-024 Starvation bound: a non-empty FIFO SHALL be granted within NUM_FU cycles.
REQ-025 pending_cnt SHALL equal the sum of all FIFO counts after each edge.
REQ-026 flush SHALL take effect at the next edge:
- empties all FIFOs;
- forces cdb_valid to 0;
- sets rr_ptr to 0;
- discards any same-cycle fu_valid offer. fu_ready may still be high, so the handshake completes and the data is dropped.
REQ-027 flush SHALL take priority over push, pop and grant in the same cycle.

Reset
REQ-028 On rst_n low, asynchronously:
- all FIFOs empty, rr_ptr=0;
- cdb_valid=0, cdb_tag=0, cdb_result=0;
- pending_cnt=0;
- fu_ready all 1 once counts are cleared.
REQ-029 Reset asserted mid-operation SHALL drop all buffered results without any broadcast.
REQ-030 The first broadcast after reset release SHALL occur no earlier than 2 edges after the first accepted result.

Verification
REQ-031 Single result: FU1 offers tag 5, data 0xDEAD_BEEF at edge 1 -> cdb_valid=1, tag 5, data 0xDEADBEEF after edge 2; cdb_valid=0 after edge 3.
REQ-032 Contention: all 4 FUs offer one result each (tags 1-4) at edge 1, with rr_ptr=0 -> CDB shows tags 1,2,3,4 on edges 2-5; pending_cnt goes 4,3,2,1,0.
REQ-033 Backpressure: FU0 offers continuously with no competitors; FU2 holds 2 entries while FU0 wins -> fu_ready[2]=0 until FU2's first grant; no result lost or duplicated.
REQ-034 Tag-zero drop: FU3 offers tag 0, data 0x1234 -> handshake completes, pending_cnt stays 0, cdb_valid stays 0.
REQ-035 Flush: 5 entries pending, flush pulsed together with a new FU0 offer -> after that edge pending_cnt=0, cdb_valid=0, rr_ptr=0; the FU0 result never appears.
REQ-036 Async reset mid-stream: rst_n dropped between edges with 3 entries pending -> outputs cleared immediately; no pending tag broadcast after release.
